// File: rtl/dbc_counter.sv
// -----------------------------------------------------------------------------
// dbc_counter -- 4-bit enabled modulo counter feeding a seven-segment decoder.
//
// Counts 0..MAX_VAL (or MAX_VAL..0 when DIR_DOWN=1), advancing once every
// PRESCALE enabled clocks. dbc_tc flags the step that wraps the count so
// stages can be cascaded (next stage's dbc_en <= this stage's dbc_tc).
//
// Parameters
//   MAX_VAL   highest count value, 1..15
//   DIR_DOWN  0 = count up, 1 = count down
//   PRESCALE  enabled clocks per count step, 1..65536
//
// Ports
//   dbc_clk  in   system clock, rising edge
//   dbc_rst  in   asynchronous active-high reset
//   dbc_en   in   count enable, sampled on dbc_clk
//   dbc_q    out  [3:0] registered count value
//   dbc_tc   out  terminal-count strobe (combinational)
// -----------------------------------------------------------------------------
module dbc_counter #(
    parameter int MAX_VAL  = 15,
    parameter bit DIR_DOWN = 1'b0,
    parameter int PRESCALE = 1
) (
    input  logic       dbc_clk,
    input  logic       dbc_rst,
    input  logic       dbc_en,
    output logic [3:0] dbc_q,
    output logic       dbc_tc
);

    localparam logic [3:0]  MAX_Q    = 4'(MAX_VAL);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    // Count value at which the next step wraps.
    localparam logic [3:0]  TC_Q     = DIR_DOWN ? 4'd0 : MAX_Q;

    logic [15:0] pre;
    logic        step;
    logic [3:0]  q_nxt;

    assign step = dbc_en & (pre == PRE_LAST);

    // Prescaler holds (does not clear) while disabled, so partial progress
    // toward the next step survives an enable gap.
    always_ff @(posedge dbc_clk or posedge dbc_rst) begin
        if (dbc_rst)
            pre <= 16'd0;
        else if (dbc_en)
            pre <= step ? 16'd0 : pre + 16'd1;
    end

    // Out-of-range values (q > MAX_VAL, only reachable through corruption)
    // fold into the wrap case so the counter self-recovers on the next step.
    always_comb begin
        q_nxt = dbc_q;
        if (DIR_DOWN) begin
            if (dbc_q == 4'd0 || dbc_q > MAX_Q)
                q_nxt = MAX_Q;
            else
                q_nxt = dbc_q - 4'd1;
        end else begin
            if (dbc_q >= MAX_Q)
                q_nxt = 4'd0;
            else
                q_nxt = dbc_q + 4'd1;
        end
    end

    always_ff @(posedge dbc_clk or posedge dbc_rst) begin
        if (dbc_rst)
            dbc_q <= 4'd0;
        else if (step)
            dbc_q <= q_nxt;
    end

    // Gated by reset: in down mode q=0 during reset would otherwise look
    // like a terminal count whenever dbc_en is high.
    assign dbc_tc = ~dbc_rst & step & (dbc_q == TC_Q);

endmodule

// File: tb/tb_dbc_counter.sv
// -----------------------------------------------------------------------------
// tb_dbc_counter -- scoreboard bench for dbc_counter.
// Four instances cover defaults, decimal+prescale, down mode and prescale hold.
// Stimulus drives inputs 2ns after the rising edge and queues the expected
// q/tc for that cycle; the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_dbc_counter;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] q;
        logic       tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en  = 4'b0;
    logic [3:0] q   [4];
    logic       tc  [4];

    exp_t  sb [$];
    int    total = 0;
    int    bad   = 0;
    bit    done  = 1'b0;
    string nm    [4] = '{"def", "dec", "dn", "pre"};

    always #5 clk = ~clk;

    dbc_counter u_def (
        .dbc_clk(clk), .dbc_rst(rst), .dbc_en(en[0]), .dbc_q(q[0]), .dbc_tc(tc[0])
    );
    dbc_counter #(.MAX_VAL(9), .PRESCALE(3)) u_dec (
        .dbc_clk(clk), .dbc_rst(rst), .dbc_en(en[1]), .dbc_q(q[1]), .dbc_tc(tc[1])
    );
    dbc_counter #(.MAX_VAL(9), .DIR_DOWN(1'b1)) u_dn (
        .dbc_clk(clk), .dbc_rst(rst), .dbc_en(en[2]), .dbc_q(q[2]), .dbc_tc(tc[2])
    );
    dbc_counter #(.PRESCALE(4)) u_pre (
        .dbc_clk(clk), .dbc_rst(rst), .dbc_en(en[3]), .dbc_q(q[3]), .dbc_tc(tc[3])
    );

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus for instance id, with the values it must show
    // in this cycle (after the edge that opened it).
    task automatic drive(input int id, input bit r, input bit e,
                         input int eq, input bit etc);
        exp_t x;
        @(posedge clk);
        #2;
        rst    = r;
        en     = '0;
        en[id] = e;
        x.id = 2'(id);
        x.q  = 4'(eq);
        x.tc = etc;
        sb.push_back(x);
    endtask

    // Monitor: every sampled cycle is an output beat.
    initial begin
        exp_t x;
        while (!done) begin
            @(negedge clk);
            while (sb.size() > 0) begin
                x = sb.pop_front();
                check({nm[x.id], ".q"},  int'(q[x.id]),  int'(x.q));
                check({nm[x.id], ".tc"}, int'(tc[x.id]), int'(x.tc));
            end
        end
    end

    // Hand-tabulated sequences.
    int dec_q [33] = '{0,0,0, 1,1,1, 2,2,2, 3,3,3, 4,4,4, 5,5,5, 6,6,6,
                       7,7,7, 8,8,8, 9,9,9, 0,0,0};
    int dn_q  [12] = '{0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    int def_q [20] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0,1,2,3};

    initial begin
        // ---- defaults: reset, count through a wrap ----
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++)
            drive(0, 0, 1, def_q[i], def_q[i] == 15);
        drive(0, 0, 1, 4, 0);               // edge after this -> 5
        // ---- enable gating at 5 ----
        for (int i = 0; i < 3; i++)
            drive(0, 0, 0, 5, 0);
        drive(0, 0, 1, 5, 0);
        drive(0, 0, 1, 6, 0);
        drive(0, 0, 1, 7, 0);
        drive(0, 0, 1, 8, 0);
        drive(0, 0, 1, 9, 0);
        // ---- asynchronous reset mid-cycle while q=9 ----
        #5;
        rst = 1'b1;
        #1;
        check("def.async_q", int'(q[0]), 0);
        check("def.async_tc", int'(tc[0]), 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 2, 0);

        // ---- MAX_VAL=9, PRESCALE=3: tc once, at sample 29 ----
        drive(1, 1, 1, 0, 0);
        for (int k = 0; k < 33; k++)
            drive(1, 0, 1, dec_q[k], k == 29);

        // ---- down mode MAX_VAL=9: reset with en=1 must keep tc low ----
        drive(2, 1, 1, 0, 0);
        drive(2, 1, 1, 0, 0);
        for (int k = 0; k < 12; k++)
            drive(2, 0, 1, dn_q[k], dn_q[k] == 0);

        // ---- PRESCALE=4: prescaler holds through an enable gap ----
        drive(3, 1, 1, 0, 0);
        drive(3, 0, 1, 0, 0);               // pre 0 -> 1
        drive(3, 0, 1, 0, 0);               // pre 1 -> 2
        for (int i = 0; i < 5; i++)
            drive(3, 0, 0, 0, 0);           // pre stays 2
        drive(3, 0, 1, 0, 0);               // pre 2 -> 3
        drive(3, 0, 1, 0, 0);               // step, q 0 -> 1
        drive(3, 0, 1, 1, 0);
        drive(3, 0, 1, 1, 0);
        drive(3, 0, 1, 1, 0);
        drive(3, 0, 1, 1, 0);               // step, q 1 -> 2
        drive(3, 0, 1, 2, 0);

        @(posedge clk);
        en = '0;
        repeat (2) @(posedge clk);
        check("sb.drained", sb.size(), 0);
        done = 1'b1;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbc_counter.md
Name: dbc_counter

Overview:
- 4-bit enabled counter ("dbc") whose output drives a seven-segment display decoder downstream.
- Counts on a prescaled clock enable, with a parameterized modulus and a build-time count direction.
- Exposes a terminal-count strobe so counters can be cascaded.
- Single clock domain; asynchronous active-high reset.

Parameters:
- MAX_VAL, 15, highest count value (1..15); the count wraps between 0 and MAX_VAL.
- DIR_DOWN, 0, 0 = count up, 1 = count down.
- PRESCALE, 1, number of dbc_clk cycles per count step (1..2^16); 1 = step on every enabled clock.

Ports:
- dbc_clk  input  1  system clock; all state updates on the rising edge.
- dbc_rst  input  1  reset, asynchronous, active-high.
- dbc_en  input  1  count enable; synchronous, sampled on the rising dbc_clk edge.
- dbc_q  output  4  current count value, registered.
- dbc_tc  output  1  terminal-count strobe, combinational.

Behaviour:
- Reset:
  - dbc_rst=1 immediately forces dbc_q=0 and the prescaler count to 0, regardless of the clock.
  - While reset is held, dbc_tc=0.
  - Release is synchronous in effect: the first step can occur on the first rising edge with dbc_rst=0.
- Prescaler:
  - 16-bit counter, pre, advances only when dbc_en=1.
  - step = dbc_en & (pre == PRESCALE-1).
  - On step, pre returns to 0; otherwise pre increments while enabled.
  - When dbc_en=0, pre holds its value; it does not clear.
  - With PRESCALE=1, step = dbc_en.
- Count, up mode (DIR_DOWN=0):
  - On step: if dbc_q == MAX_VAL, dbc_q becomes 0; otherwise dbc_q+1.
  - No other case changes dbc_q.
- Count, down mode (DIR_DOWN=1):
  - On step: if dbc_q == 0, dbc_q becomes MAX_VAL; otherwise dbc_q-1.
- dbc_en=0: dbc_q holds.
- Latency: dbc_q changes on the same rising edge at which step is true (one-edge latency from the enable sample).
- dbc_tc:
  - Equals step & (dbc_q == MAX_VAL) in up mode.
  - Equals step & (dbc_q == 0) in down mode.
  - It is high for exactly one clock, the cycle before the wrap edge.
- Out-of-range value:
  - Arises only if MAX_VAL < 15 and a glitch corrupts state.
  - If dbc_q > MAX_VAL, the next step loads 0 (up mode) or MAX_VAL (down mode).
- Arithmetic is 4-bit unsigned; no saturation. Wrap-around follows the rules above only.
- Reset mid-count overrides everything, including a coincident step; the counter resumes from 0.

Test Plan:
- Reset then count, defaults: dbc_rst=1, dbc_en=1 for 1 cycle, then dbc_rst=0 for 20 cycles.
  - dbc_q=0 during reset, then 1,2,…,15,0,1,2,3,4 on successive edges.
  - dbc_tc high only in the cycle where dbc_q=15.
- Enable gating: after the count reaches 5, drop dbc_en for 3 cycles.
  - dbc_q stays 5 and dbc_tc stays 0.
  - With dbc_en back at 1, the next edge gives 6.
- Asynchronous reset: assert dbc_rst mid-cycle while dbc_q=9.
  - dbc_q goes to 0 before the next clock edge.
  - It stays 0 until release, then counts 1,2,….
- Decimal modulus and prescaler: MAX_VAL=9, PRESCALE=3, dbc_en=1 for 33 cycles after reset.
  - dbc_q steps every 3rd edge: 0,0,0,1,1,1,…,9 then wraps to 0.
  - dbc_tc pulses once, for one cycle, at dbc_q=9.
- Down mode: DIR_DOWN=1, MAX_VAL=9, dbc_en=1 after reset.
  - dbc_q sequence 0,9,8,…,1,0,9.
  - dbc_tc pulses in each cycle where dbc_q=0 and the count is enabled.
- Prescaler hold: PRESCALE=4; enable 2 cycles, disable 5 cycles, re-enable.
  - The first step occurs exactly 2 enabled cycles after re-enable.
  - dbc_q goes 0 to 1 at that point.
